// File: rtl/ctrl_74hc165_pkg.sv
// Shared constants for the 74HC165 scan controller: FSM encoding and parameter limits.
package hc165_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_SHIFT_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT_HI = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      LOAD     = ST_LOAD,
      SHIFT_LO = ST_SHIFT_LO,
      SHIFT_HI = ST_SHIFT_HI,
      DONE     = ST_DONE
   } state_t;

   // Below three cycles per phase the 2-FF synchronizer could sample a stale bit.
   localparam int MIN_CLK_DIV = 3;
   localparam int MIN_DATA_W  = 2;

endpackage

// File: rtl/ctrl_74hc165_if.sv
// Pin and result bundle of the 74HC165 scan controller; o_changed exists only with CTRL_74HC165_CHG_EN.
interface ctrl_74hc165_if #(
   parameter int DATA_W = 16
);
   logic              i_en;
   logic              i_q7;
   logic              o_pl_n;
   logic              o_cp;
   logic              o_ce_n;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
`ifdef CTRL_74HC165_CHG_EN
   logic              o_changed;

   modport master (
      input  i_en, i_q7,
      output o_pl_n, o_cp, o_ce_n, o_data, o_valid, o_changed
   );
   modport slave (
      output i_en, i_q7,
      input  o_pl_n, o_cp, o_ce_n, o_data, o_valid, o_changed
   );
`else
   modport master (
      input  i_en, i_q7,
      output o_pl_n, o_cp, o_ce_n, o_data, o_valid
   );
   modport slave (
      output i_en, i_q7,
      input  o_pl_n, o_cp, o_ce_n, o_data, o_valid
   );
`endif
endinterface

// File: rtl/ctrl_74hc165_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/ctrl_74hc165.sv
// Reader for a 74HC165 PISO chain: loads, clocks DATA_W bits MSB-first and publishes the word with a 1-cycle strobe.
// Optional CTRL_74HC165_CHG_EN adds o_changed, flagging a published word that differs from the previous one.
module ctrl_74hc165
   import hc165_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 4
) (
   input  logic           clk,
   input  logic           rst,
   ctrl_74hc165_if.master bus
);
   localparam int PW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_W);
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

   generate
      if (CLK_DIV < MIN_CLK_DIV) begin : g_bad_clk_div
         $error("ctrl_74hc165: CLK_DIV below minimum");
      end
      if (DATA_W < MIN_DATA_W) begin : g_bad_data_w
         $error("ctrl_74hc165: DATA_W below minimum");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [DATA_W-1:0] data_q;
   logic              publish;
   logic              phase_last;
   logic              q7_s;
   logic              pl_n_q, cp_q, ce_n_q, valid_q;

   sync_2ff u_sync_q7 (
      .clk (clk),
      .rst (rst),
      .d   (bus.i_q7),
      .q   (q7_s)
   );

   assign phase_last = (phase_q == PH_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      publish = 1'b0;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (bus.i_en) state_d = LOAD;
         end
         LOAD: begin
            if (phase_last) begin
               phase_d = '0;
               bit_d   = BIT_TOP;
               state_d = SHIFT_LO;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         SHIFT_LO: begin
            // Sample late in the low phase so q7_s has settled after the last CP rise.
            if (phase_last) begin
               phase_d = '0;
               sr_d    = {sr_q[DATA_W-2:0], q7_s};
               state_d = (bit_q == '0) ? DONE : SHIFT_HI;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         SHIFT_HI: begin
            if (phase_last) begin
               phase_d = '0;
               bit_d   = bit_q - 1'b1;
               state_d = SHIFT_LO;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         DONE: begin
            publish = 1'b1;
            phase_d = '0;
            state_d = bus.i_en ? LOAD : IDLE;
         end
         default: begin
            phase_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Pins are decoded from the next state so they are registered yet aligned with the FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pl_n_q  <= 1'b1;
         cp_q    <= 1'b0;
         ce_n_q  <= 1'b1;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         pl_n_q  <= (state_d != LOAD);
         cp_q    <= (state_d == SHIFT_HI);
         ce_n_q  <= (state_d == IDLE);
         valid_q <= publish;
         if (publish) data_q <= sr_q;
      end
   end

`ifdef CTRL_74HC165_CHG_EN
   logic changed_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) changed_q <= 1'b0;
      else     changed_q <= publish && (sr_q != data_q);
   end

   assign bus.o_changed = changed_q;
`endif

   assign bus.o_pl_n  = pl_n_q;
   assign bus.o_cp    = cp_q;
   assign bus.o_ce_n  = ce_n_q;
   assign bus.o_valid = valid_q;
   assign bus.o_data  = data_q;

endmodule
